// File: rtl/design1_wrapper.sv
// AXI4-Lite controlled SPI master with TX/RX byte FIFOs, programmable SCLK
// divider and a level interrupt output (dbg).
module design1_wrapper #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] VERSION    = 32'h00010100
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [5:0]  s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [5:0]  s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        SPI_CS_N,
  output logic        dbg,
  output logic        sd
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE_CNT  = {{AW{1'b0}}, 1'b1};

  localparam logic [3:0] A_CTRL = 4'h0, A_STAT = 4'h1, A_DIV = 4'h2, A_TX  = 4'h3,
                         A_RX   = 4'h4, A_IER  = 4'h5, A_ISR = 4'h6, A_CS  = 4'h7,
                         A_VER  = 4'h8, A_START = 4'h9, A_RST = 4'hA;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;
  state_t state, state_n;

  logic [3:0]  wa, ra;
  logic        wr_hs, rd_hs, start_cmd, soft_rst;
  logic [2:0]  ctrl;
  logic [15:0] clk_div;
  logic [1:0]  ier, isr, isr_set;
  logic        cs, overflow;
  logic [31:0] rd_val;

  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [AW:0]   tx_cnt, rx_cnt;
  logic          tx_push, tx_pop, rx_push, rx_pop;
  logic          tx_empty, tx_full, rx_empty, rx_full;

  logic        cfg_cpol, cfg_cpha, cfg_lsb;
  logic [15:0] cfg_half, div_cnt;
  logic [3:0]  edge_cnt;
  logic [7:0]  sh, rx_sh, rx_next, rx_byte;
  logic        sclk_r, mosi_r, sd_r;
  logic        tick, sample, shift_ev, byte_done;

  logic unused_bits;
  assign unused_bits = ^{s_axi_wstrb, s_axi_wdata[31:16], s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  function automatic logic first_bit(input logic [7:0] b, input logic lsb);
    return lsb ? b[0] : b[7];
  endfunction

  function automatic logic [7:0] shift_byte(input logic [7:0] b, input logic lsb);
    return lsb ? {1'b0, b[7:1]} : {b[6:0], 1'b0};
  endfunction

  assign wa        = s_axi_awaddr[5:2];
  assign ra        = s_axi_araddr[5:2];
  assign wr_hs     = s_axi_awready & s_axi_awvalid & s_axi_wvalid;
  assign rd_hs     = s_axi_arready & s_axi_arvalid;
  assign start_cmd = wr_hs && wa == A_START && s_axi_wdata[0];
  assign soft_rst  = wr_hs && wa == A_RST && s_axi_wdata[0];

  assign tx_empty = tx_cnt == '0;
  assign tx_full  = tx_cnt == FULL_CNT;
  assign rx_empty = rx_cnt == '0;
  assign rx_full  = rx_cnt == FULL_CNT;

  assign tx_push = wr_hs && wa == A_TX && !tx_full && !soft_rst;
  assign tx_pop  = state == S_LOAD && !tx_empty && !soft_rst;
  assign rx_pop  = rd_hs && ra == A_RX && !rx_empty && !soft_rst;

  // Bit timing: a tick is one SCLK edge; even edges lead, odd edges trail.
  // The sample edge is leading when CPHA=0 and trailing when CPHA=1.
  assign tick      = state == S_SHIFT && div_cnt == cfg_half - 16'd1;
  assign sample    = tick && (~edge_cnt[0] ^ cfg_cpha);
  assign shift_ev  = tick && !(~edge_cnt[0] ^ cfg_cpha);
  assign byte_done = tick && edge_cnt == 4'd15;
  assign rx_next   = cfg_lsb ? {miso, rx_sh[7:1]} : {rx_sh[6:0], miso};
  assign rx_byte   = sample ? rx_next : rx_sh;
  assign rx_push   = byte_done && !rx_full && !soft_rst;

  assign isr_set[0] = tx_pop && tx_cnt == ONE_CNT && !tx_push;
  assign isr_set[1] = state == S_DONE || (start_cmd && state == S_IDLE && tx_empty);

  assign s_axi_wready = s_axi_awready;
  assign s_axi_bresp  = 2'b00;
  assign s_axi_rresp  = 2'b00;
  assign sclk     = sclk_r;
  assign mosi     = mosi_r;
  assign sd       = sd_r;
  assign SPI_CS_N = cs;
  assign dbg      = |(isr & ier);

  // AXI handshakes: single-cycle ready pulses, responses held until accepted
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      s_axi_awready <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
    end else begin
      s_axi_awready <= s_axi_awvalid & s_axi_wvalid & ~s_axi_awready & ~s_axi_bvalid;
      s_axi_arready <= s_axi_arvalid & ~s_axi_arready & ~s_axi_rvalid;
      if (wr_hs) s_axi_bvalid <= 1'b1;
      else if (s_axi_bready) s_axi_bvalid <= 1'b0;
      if (rd_hs) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_val;
      end else if (s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

  // Read data mux
  always_comb begin
    rd_val = '0;
    case (ra)
      A_CTRL: rd_val = {29'h0, ctrl};
      A_STAT: rd_val = {26'h0, overflow, tx_full, tx_empty, rx_full, rx_empty, state != S_IDLE};
      A_DIV:  rd_val = {16'h0, clk_div};
      A_RX:   rd_val = rx_empty ? '0 : {24'h0, rx_mem[rx_rp]};
      A_IER:  rd_val = {30'h0, ier};
      A_ISR:  rd_val = {30'h0, isr};
      A_CS:   rd_val = {31'h0, cs};
      A_VER:  rd_val = VERSION;
      default: rd_val = '0;
    endcase
  end

  // Control registers; on ISR a set event wins over a same-cycle W1C
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ctrl <= '0; clk_div <= '0; ier <= '0; isr <= '0; cs <= 1'b1; overflow <= 1'b0;
    end else begin
      if (wr_hs && wa == A_CTRL) ctrl <= s_axi_wdata[2:0];
      if (wr_hs && wa == A_DIV)  clk_div <= s_axi_wdata[15:0];
      if (wr_hs && wa == A_IER)  ier <= s_axi_wdata[1:0];
      if (wr_hs && wa == A_CS)   cs <= s_axi_wdata[0];
      if (soft_rst) begin
        isr      <= '0;
        overflow <= 1'b0;
      end else begin
        isr <= ((wr_hs && wa == A_ISR) ? (isr & ~s_axi_wdata[1:0]) : isr) | isr_set;
        if (byte_done && rx_full) overflow <= 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge aclk) begin
    if (!aresetn || soft_rst) begin
      tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
      rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      tx_cnt <= tx_cnt + {{AW{1'b0}}, tx_push} - {{AW{1'b0}}, tx_pop};
      rx_cnt <= rx_cnt + {{AW{1'b0}}, rx_push} - {{AW{1'b0}}, rx_pop};
    end
  end

  // FIFO storage
  always_ff @(posedge aclk) begin
    if (tx_push) tx_mem[tx_wp] <= s_axi_wdata[7:0];
    if (rx_push) rx_mem[rx_wp] <= rx_byte;
  end

  // Exchange sequencer state register
  always_ff @(posedge aclk) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= state_n;
  end

  // Exchange sequencer next state
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start_cmd && !tx_empty) state_n = S_LOAD;
      S_LOAD:  state_n = S_SHIFT;
      S_SHIFT: if (byte_done) state_n = tx_empty ? S_DONE : S_LOAD;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (soft_rst) state_n = S_IDLE;
  end

  // Shifter, SCLK generation and per-exchange configuration snapshot
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      sclk_r <= 1'b0; mosi_r <= 1'b0; sd_r <= 1'b0;
      sh <= '0; rx_sh <= '0; div_cnt <= '0; edge_cnt <= '0;
      cfg_cpol <= 1'b0; cfg_cpha <= 1'b0; cfg_lsb <= 1'b0; cfg_half <= 16'd1;
    end else begin
      sd_r <= sample && !soft_rst;
      if (soft_rst) begin
        sclk_r <= ctrl[0];
        mosi_r <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            sclk_r <= ctrl[0];
            mosi_r <= 1'b0;
            if (start_cmd) begin
              cfg_cpol <= ctrl[0];
              cfg_cpha <= ctrl[1];
              cfg_lsb  <= ctrl[2];
              cfg_half <= (clk_div == 16'd0) ? 16'd1 : clk_div;
            end
          end
          S_LOAD: begin
            sclk_r   <= cfg_cpol;
            div_cnt  <= '0;
            edge_cnt <= '0;
            rx_sh    <= '0;
            if (!cfg_cpha) begin
              mosi_r <= first_bit(tx_mem[tx_rp], cfg_lsb);
              sh     <= shift_byte(tx_mem[tx_rp], cfg_lsb);
            end else begin
              sh <= tx_mem[tx_rp];
            end
          end
          S_SHIFT: begin
            if (tick) begin
              sclk_r   <= ~sclk_r;
              div_cnt  <= '0;
              edge_cnt <= edge_cnt + 4'd1;
              if (sample) rx_sh <= rx_next;
              if (shift_ev) begin
                mosi_r <= first_bit(sh, cfg_lsb);
                sh     <= shift_byte(sh, cfg_lsb);
              end
            end else begin
              div_cnt <= div_cnt + 16'd1;
            end
          end
          S_DONE: begin
            sclk_r <= cfg_cpol;
            mosi_r <= 1'b0;
          end
          default: sclk_r <= cfg_cpol;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_design1_wrapper.sv
// Self-checking bench for design1_wrapper: register table, loopback
// exchanges in all SPI modes, FIFO boundaries, overflow and soft reset.
`timescale 1ns/1ps
module tb_design1_wrapper;

  logic        aclk = 1'b0, aresetn = 1'b0;
  logic [5:0]  awaddr = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        sclk, mosi, miso, SPI_CS_N, dbg, sd;

  assign miso = mosi;

  always #5 aclk = ~aclk;

  design1_wrapper #(.FIFO_DEPTH(16), .VERSION(32'h00010100)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .sclk(sclk), .mosi(mosi), .miso(miso), .SPI_CS_N(SPI_CS_N), .dbg(dbg), .sd(sd)
  );

  int  n_cmp = 0, n_bad = 0;
  int  sclk_pos = 0, sd_cnt = 0, cs_bad = 0;
  bit  cs_watch = 1'b0;
  time t_last = 0, t_prev = 0;
  int  s0, d0;
  logic [31:0] sb_q[$];

  always @(posedge sclk) begin
    t_prev = t_last;
    t_last = $time;
    sclk_pos++;
  end

  always @(posedge aclk) begin
    if (sd === 1'b1) sd_cnt++;
    if (cs_watch && SPI_CS_N !== 1'b0) cs_bad++;
  end

  typedef struct {
    bit          do_wr;
    logic [5:0]  addr;
    logic [31:0] wdat;
    logic [31:0] exp;
    string       nm;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timeout waiting for DUT", nm);
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d);
    int t;
    awaddr = a; wdata = d; wstrb = '1; awvalid = 1'b1; wvalid = 1'b1;
    t = 0;
    while (awready !== 1'b1 && t < 20) begin @(posedge aclk); #1; t++; end
    if (awready !== 1'b1) timeout("awready");
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    t = 0;
    while (bvalid !== 1'b1 && t < 20) begin @(posedge aclk); #1; t++; end
    if (bvalid !== 1'b1) timeout("bvalid");
    @(posedge aclk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d);
    int t;
    araddr = a; arvalid = 1'b1;
    t = 0;
    while (arready !== 1'b1 && t < 20) begin @(posedge aclk); #1; t++; end
    if (arready !== 1'b1) timeout("arready");
    @(posedge aclk); #1;
    arvalid = 1'b0;
    t = 0;
    while (rvalid !== 1'b1 && t < 20) begin @(posedge aclk); #1; t++; end
    if (rvalid !== 1'b1) timeout("rvalid");
    d = rdata;
    rready = 1'b1;
    @(posedge aclk); #1;
    rready = 1'b0;
  endtask

  // Expected value is queued when the read is issued and retired when data returns
  task automatic read_chk(input string nm, input logic [5:0] a, input logic [31:0] exp);
    logic [31:0] d, e;
    sb_q.push_back(exp);
    axi_read(a, d);
    e = sb_q.pop_front();
    chk(nm, d, e);
  endtask

  task automatic push_tx(input logic [7:0] b);
    axi_write(6'h0C, {24'h0, b});
  endtask

  task automatic wait_dbg(input string nm);
    int t;
    t = 0;
    while (dbg !== 1'b1 && t < 100000) begin @(posedge aclk); #1; t++; end
    if (dbg !== 1'b1) timeout(nm);
  endtask

  initial begin
    logic [7:0] xb [4];
    xb[0] = 8'hDE; xb[1] = 8'hAD; xb[2] = 8'hBE; xb[3] = 8'hEF;

    vt.push_back('{1'b0, 6'h20, 32'h0, 32'h00010100, "rst_version"});
    vt.push_back('{1'b0, 6'h04, 32'h0, 32'h0000000A, "rst_status"});
    vt.push_back('{1'b0, 6'h1C, 32'h0, 32'h00000001, "rst_cs"});
    vt.push_back('{1'b0, 6'h00, 32'h0, 32'h00000000, "rst_ctrl"});
    vt.push_back('{1'b0, 6'h08, 32'h0, 32'h00000000, "rst_clkdiv"});
    vt.push_back('{1'b0, 6'h14, 32'h0, 32'h00000000, "rst_ier"});
    vt.push_back('{1'b0, 6'h18, 32'h0, 32'h00000000, "rst_isr"});
    vt.push_back('{1'b0, 6'h10, 32'h0, 32'h00000000, "rx_empty_read"});
    vt.push_back('{1'b0, 6'h2C, 32'h0, 32'h00000000, "unmapped_read"});
    vt.push_back('{1'b1, 6'h00, 32'hFFFFFFFF, 32'h00000007, "ctrl_rw"});
    vt.push_back('{1'b1, 6'h08, 32'hABCD1234, 32'h00001234, "clkdiv_rw"});
    vt.push_back('{1'b1, 6'h14, 32'h000000FF, 32'h00000003, "ier_rw"});
    vt.push_back('{1'b1, 6'h1C, 32'hFFFFFFFE, 32'h00000000, "cs_rw"});
    vt.push_back('{1'b1, 6'h18, 32'h00000003, 32'h00000000, "isr_w1c_idle"});
    vt.push_back('{1'b1, 6'h3C, 32'h12345678, 32'h00000000, "unmapped_write"});
    vt.push_back('{1'b1, 6'h20, 32'h00000000, 32'h00010100, "version_ro"});

    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("rst_pins", {27'h0, sclk, mosi, SPI_CS_N, dbg, sd}, 32'h00000004);

    foreach (vt[i]) begin
      if (vt[i].do_wr) axi_write(vt[i].addr, vt[i].wdat);
      read_chk(vt[i].nm, vt[i].addr, vt[i].exp);
    end

    // MSB-first mode 0 loopback, four bytes, DIV=4
    axi_write(6'h00, 32'h0);
    axi_write(6'h08, 32'd4);
    axi_write(6'h14, 32'h2);
    axi_write(6'h1C, 32'h0);
    for (int i = 0; i < 4; i++) push_tx(xb[i]);
    s0 = sclk_pos; d0 = sd_cnt; cs_watch = 1'b1;
    axi_write(6'h24, 32'h1);
    wait_dbg("xfer1_dbg");
    cs_watch = 1'b0;
    chk("xfer1_sclk_period", 32'(t_last - t_prev), 32'd80);
    chk("xfer1_sclk_edges", 32'(sclk_pos - s0), 32'd32);
    chk("xfer1_sd_count", 32'(sd_cnt - d0), 32'd32);
    chk("xfer1_cs_low", 32'(cs_bad), 32'd0);
    chk("xfer1_sclk_idle", {31'h0, sclk}, 32'h0);
    axi_write(6'h1C, 32'h1);
    axi_write(6'h18, 32'h2);
    chk("dbg_cleared", {31'h0, dbg}, 32'h0);
    chk("cs_n_high", {31'h0, SPI_CS_N}, 32'h1);
    for (int i = 0; i < 4; i++) read_chk("xfer1_rx", 6'h10, {24'h0, xb[i]});
    read_chk("xfer1_status", 6'h04, 32'h0000000A);
    read_chk("xfer1_isr_txempty", 6'h18, 32'h00000001);
    axi_write(6'h18, 32'h3);

    // LSB first
    axi_write(6'h00, 32'h4);
    push_tx(8'h12); push_tx(8'h34);
    axi_write(6'h24, 32'h1);
    wait_dbg("lsb_dbg");
    axi_write(6'h18, 32'h3);
    read_chk("lsb_rx0", 6'h10, 32'h12);
    read_chk("lsb_rx1", 6'h10, 32'h34);
    read_chk("lsb_status", 6'h04, 32'h0000000A);

    // START with TX empty
    s0 = sclk_pos;
    axi_write(6'h24, 32'h1);
    read_chk("empty_start_isr", 6'h18, 32'h00000002);
    chk("empty_start_edges", 32'(sclk_pos - s0), 32'd0);
    chk("empty_start_dbg", {31'h0, dbg}, 32'h1);
    axi_write(6'h18, 32'h3);

    // 17 pushes: 17th dropped, 16 transferred
    axi_write(6'h00, 32'h0);
    for (int i = 0; i < 17; i++) push_tx(8'(8'h40 + i));
    read_chk("tx_full_status", 6'h04, 32'h00000012);
    d0 = sd_cnt;
    axi_write(6'h24, 32'h1);
    wait_dbg("full_dbg");
    axi_write(6'h18, 32'h3);
    chk("full_sd_count", 32'(sd_cnt - d0), 32'd128);
    read_chk("rx_full_status", 6'h04, 32'h0000000C);
    for (int i = 0; i < 16; i++) read_chk("full_rx", 6'h10, {24'h0, 8'(8'h40 + i)});
    read_chk("full_drain_status", 6'h04, 32'h0000000A);

    // 17-byte exchange with RX never read
    for (int i = 0; i < 16; i++) push_tx(8'(i));
    axi_write(6'h24, 32'h1);
    push_tx(8'h99);
    wait_dbg("ovf_dbg");
    read_chk("ovf_status", 6'h04, 32'h0000002C);
    axi_write(6'h28, 32'h1);
    read_chk("ovf_reset_status", 6'h04, 32'h0000000A);
    read_chk("ovf_reset_isr", 6'h18, 32'h0);
    read_chk("ovf_reset_rx", 6'h10, 32'h0);

    // Soft reset mid-exchange
    for (int i = 0; i < 4; i++) push_tx(8'hA0);
    axi_write(6'h24, 32'h1);
    repeat (20) @(posedge aclk);
    #1;
    read_chk("mid_busy_status", 6'h04, 32'h00000003);
    axi_write(6'h28, 32'h1);
    read_chk("mid_reset_status", 6'h04, 32'h0000000A);
    s0 = sclk_pos;
    repeat (200) @(posedge aclk);
    #1;
    chk("mid_reset_quiet", 32'(sclk_pos - s0), 32'd0);
    read_chk("mid_reset_isr", 6'h18, 32'h0);

    // Modes 1..3 in loopback
    for (int m = 1; m <= 3; m++) begin
      logic [7:0] b0, b1;
      logic       cpol;
      b0 = 8'(8'h5A + m * 17);
      b1 = 8'(8'hC3 - m);
      cpol = (m % 2) == 1;
      axi_write(6'h00, 32'(m));
      chk("mode_idle_sclk", {31'h0, sclk}, {31'h0, cpol});
      s0 = sclk_pos; d0 = sd_cnt;
      push_tx(b0); push_tx(b1);
      axi_write(6'h24, 32'h1);
      wait_dbg("mode_dbg");
      chk("mode_end_sclk", {31'h0, sclk}, {31'h0, cpol});
      chk("mode_sd_count", 32'(sd_cnt - d0), 32'd16);
      chk("mode_sclk_edges", 32'(sclk_pos - s0), 32'd16);
      axi_write(6'h18, 32'h3);
      read_chk("mode_rx0", 6'h10, {24'h0, b0});
      read_chk("mode_rx1", 6'h10, {24'h0, b1});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
